mem_lsu_stage: RTL
==================

MEM_LSU_STAGE -- requirements
Module: mem_lsu_stage

Interface
REQ-001 Parameter DATA_W, default 32, data bus and result width; legal values 32 or 64.
REQ-002 Parameter MAX_DISCARD, default 3, maximum number of cancelled outstanding responses tracked; legal range 1..7.
REQ-003 Local OFS_W = log2(DATA_W/8): 2 when DATA_W=32, 3 when DATA_W=64.
REQ-004 clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 es_to_ms_valid  in  1  EX holds a valid instruction.
REQ-007 ms_allowin  out  1  MEM accepts an instruction this cycle.
REQ-008 es_mem_req  in  1  the instruction's data request has already been accepted by the bus.
REQ-009 es_ld_op  in  3  load type: 0 none, 1 ld.b, 2 ld.bu, 3 ld.h, 4 ld.hu, 5 ld.w, 6 ld.wu, 7 ld.d.
REQ-010 es_addr_low  in  OFS_W  low address bits of the access.
REQ-011 es_gr_we / es_dest / es_alu_result / es_pc  in  1/5/DATA_W/32  writeback fields.
REQ-012 data_ok / data_rdata  in  1/DATA_W  read response strobe and response data.
REQ-013 flush  in  1  cancels the instruction held in MEM.
REQ-014 ws_allowin  in  1; ms_to_ws_valid  out  1.
REQ-015 ms_gr_we / ms_dest / ms_final_result / ms_pc  out  1/5/DATA_W/32.
REQ-016 ms_ld_wait  out  1  MEM holds a load whose data is not yet available (used to stall forwarding).

Function
REQ-017 Fields SHALL be registered when es_to_ms_valid && ms_allowin && !flush; ms_valid SHALL be loaded from (es_to_ms_valid && !flush) whenever ms_allowin=1 or flush=1.
REQ-018 ms_allowin SHALL equal (!ms_valid || (ms_ready_go && ws_allowin)) && (discard_cnt != MAX_DISCARD).
REQ-019 A live response SHALL be data_ok && discard_cnt==0.
REQ-020 ms_ready_go SHALL be !ms_mem_req || buf_valid || live response.
REQ-021 ms_to_ws_valid SHALL be ms_valid && ms_ready_go && !flush.
REQ-022 Response buffer (one entry): on a live response while ms_valid && ms_mem_req && !buf_valid && !(ws_allowin && !flush), the buffer SHALL capture data_rdata and set buf_valid.
REQ-023 buf_valid SHALL clear on the cycle the instruction leaves (ms_to_ws_valid && ws_allowin) or on flush.
REQ-024 Load data SHALL be taken from the buffer when buf_valid=1, else from data_rdata.
REQ-025 Byte lane SHALL be selected by es_addr_low; halfword by es_addr_low[OFS_W-1:1]; word by es_addr_low[OFS_W-1:2] (always lane 0 when DATA_W=32).
REQ-026 Signed loads SHALL sign-extend to DATA_W; unsigned loads SHALL zero-extend.
REQ-027 ld.wu and ld.d with DATA_W=32 SHALL behave as ld.w.
REQ-028 A misaligned halfword, word or doubleword load SHALL return 0.
REQ-029 ms_final_result SHALL be the extracted load data when es_ld_op!=0, else ms_alu_result.
REQ-030 Discard counter: flush while ms_valid && ms_mem_req && !buf_valid && no live response SHALL increment discard_cnt.
REQ-031 Any data_ok while discard_cnt>0 SHALL be dropped and SHALL decrement discard_cnt.
REQ-032 When an increment and a decrement occur in the same cycle, discard_cnt SHALL remain unchanged.
REQ-033 discard_cnt SHALL saturate at MAX_DISCARD.
REQ-034 Flush in the same cycle as the live response of the held instruction SHALL NOT increment discard_cnt; the data SHALL be dropped.
REQ-035 ms_ld_wait SHALL be ms_valid && es_ld_op!=0 && !ms_ready_go.
REQ-036 Latency: a load with data_ok in the same cycle as ws_allowin SHALL produce ms_to_ws_valid in that cycle (zero added cycles).

Reset
REQ-037 While resetn=0: ms_valid, buf_valid and discard_cnt SHALL be 0, so ms_to_ws_valid=0, ms_ld_wait=0 and ms_allowin=1.
REQ-038 Datapath registers SHALL reset to 0, so ms_gr_we=0, ms_dest=0, ms_pc=0 and ms_final_result=0.
REQ-039 Reset assertion mid-transaction SHALL abandon all pending responses without tracking them.

Verification
REQ-040 ld.b, addr_low=3, data_rdata=0x80FF_0000, data_ok with ws_allowin=1 -> result 0xFFFF_FF80 in the same cycle.
REQ-041 ld.hu, addr_low=2, data_ok while ws_allowin=0 for 3 cycles, data_rdata then changes -> buffered value 0x0000_80FF is output when ws_allowin rises.
REQ-042 Load flushed before data_ok -> discard_cnt=1; the next data_ok is dropped; the following load is unaffected.
REQ-043 Three consecutive flushed loads (MAX_DISCARD=3) -> ms_allowin=0 until one data_ok returns, then 1.
REQ-044 DATA_W=64: ld.d at addr_low=0 returns the full word; ld.w at addr_low=4 returns the upper half sign-extended; ld.h at addr_low=1 returns 0.
REQ-045 resetn pulled low while buf_valid=1 and discard_cnt=2 -> all outputs match REQ-037 and REQ-038 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: MEM pipeline stage of a load/store unit.
//   Holds one instruction between EX and WB, waits for its read response,
//   extracts and extends the load data, and keeps a small count of responses
//   that belong to cancelled loads so those late responses are dropped.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   es_to_ms_valid / ms_allowin EX->MEM handshake
//   es_mem_req, es_ld_op, es_addr_low, es_gr_we, es_dest, es_alu_result, es_pc
//                               instruction fields captured on entry
//   data_ok / data_rdata        read response strobe and data
//   flush                       cancel the instruction held in MEM
//   ws_allowin / ms_to_ws_valid MEM->WB handshake
//   ms_gr_we, ms_dest, ms_final_result, ms_pc  writeback fields
//   ms_ld_wait                  load held here without data yet
module mem_lsu_stage #(
    parameter int DATA_W      = 32,
    parameter int MAX_DISCARD = 3,
    localparam int OFS_W      = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic              es_mem_req,
    input  logic [2:0]        es_ld_op,
    input  logic [OFS_W-1:0]  es_addr_low,
    input  logic              es_gr_we,
    input  logic [4:0]        es_dest,
    input  logic [DATA_W-1:0] es_alu_result,
    input  logic [31:0]       es_pc,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              flush,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic              ms_gr_we,
    output logic [4:0]        ms_dest,
    output logic [DATA_W-1:0] ms_final_result,
    output logic [31:0]       ms_pc,
    output logic              ms_ld_wait
);

    logic              ms_valid;
    logic              ms_mem_req;
    logic [2:0]        ms_ld_op;
    logic [OFS_W-1:0]  ms_ofs;
    logic [DATA_W-1:0] ms_alu_result;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic [2:0]        discard_cnt;

    logic live;
    logic ms_ready_go;
    logic leave;
    logic buf_cap;
    logic cnt_inc;
    logic cnt_dec;

    // A response only belongs to the held load once every cancelled
    // response ahead of it has drained.
    assign live           = data_ok && (discard_cnt == 3'd0);
    assign ms_ready_go    = !ms_mem_req || buf_valid || live;
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign ms_allowin     = (!ms_valid || (ms_ready_go && ws_allowin))
                            && (discard_cnt != 3'(MAX_DISCARD));
    assign leave          = ms_to_ws_valid && ws_allowin;
    assign ms_ld_wait     = ms_valid && (ms_ld_op != 3'd0) && !ms_ready_go;

    // Capture the response only when it cannot be consumed right now;
    // the bus presents data_rdata for a single cycle.
    assign buf_cap = live && ms_valid && ms_mem_req && !buf_valid
                     && !(ws_allowin && !flush);

    // A flushed load whose response is still in flight leaves one
    // response to be dropped later.
    assign cnt_inc = flush && ms_valid && ms_mem_req && !buf_valid && !live;
    assign cnt_dec = data_ok && (discard_cnt != 3'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin || flush) begin
            ms_valid <= es_to_ms_valid && !flush;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_mem_req    <= 1'b0;
            ms_ld_op      <= 3'd0;
            ms_ofs        <= '0;
            ms_gr_we      <= 1'b0;
            ms_dest       <= 5'd0;
            ms_alu_result <= '0;
            ms_pc         <= 32'd0;
        end else if (es_to_ms_valid && ms_allowin && !flush) begin
            ms_mem_req    <= es_mem_req;
            ms_ld_op      <= es_ld_op;
            ms_ofs        <= es_addr_low;
            ms_gr_we      <= es_gr_we;
            ms_dest       <= es_dest;
            ms_alu_result <= es_alu_result;
            ms_pc         <= es_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (flush || leave) begin
            buf_valid <= 1'b0;
        end else if (buf_cap) begin
            buf_valid <= 1'b1;
            buf_data  <= data_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt <= 3'd0;
        end else if (cnt_inc && !cnt_dec) begin
            if (discard_cnt != 3'(MAX_DISCARD)) discard_cnt <= discard_cnt + 3'd1;
        end else if (cnt_dec && !cnt_inc) begin
            discard_cnt <= discard_cnt - 3'd1;
        end
    end

    // Load data extraction
    logic [DATA_W-1:0] rdata;
    logic [OFS_W+2:0]  byte_base;
    logic [OFS_W+2:0]  half_base;
    logic [OFS_W+2:0]  word_base;
    logic [7:0]        b_data;
    logic [15:0]       h_data;
    logic [31:0]       w_data;
    logic              mis_h;
    logic              mis_w;
    logic              mis_d;
    logic [DATA_W-1:0] ld_data;

    assign rdata     = buf_valid ? buf_data : data_rdata;
    // Lane bases in bits; masking the offset picks the aligned lane and
    // collapses the word lane to 0 on a 32-bit bus.
    assign byte_base = {ms_ofs, 3'b000};
    assign half_base = {ms_ofs & ~OFS_W'(1), 3'b000};
    assign word_base = {ms_ofs & ~OFS_W'(3), 3'b000};
    assign b_data    = rdata[byte_base +: 8];
    assign h_data    = rdata[half_base +: 16];
    assign w_data    = rdata[word_base +: 32];
    assign mis_h     = ms_ofs[0];
    assign mis_w     = |(ms_ofs & OFS_W'(3));
    assign mis_d     = (DATA_W == 64) ? |ms_ofs : mis_w;

    always_comb begin
        ld_data = '0;
        case (ms_ld_op)
            3'd1: ld_data = DATA_W'($signed(b_data));
            3'd2: ld_data = DATA_W'(b_data);
            3'd3: ld_data = mis_h ? '0 : DATA_W'($signed(h_data));
            3'd4: ld_data = mis_h ? '0 : DATA_W'(h_data);
            3'd5: ld_data = mis_w ? '0 : DATA_W'($signed(w_data));
            // On a 32-bit bus ld.wu and ld.d fold into ld.w.
            3'd6: ld_data = mis_w ? '0 : ((DATA_W == 64) ? DATA_W'(w_data)
                                                         : DATA_W'($signed(w_data)));
            3'd7: ld_data = mis_d ? '0 : ((DATA_W == 64) ? rdata
                                                         : DATA_W'($signed(w_data)));
            default: ld_data = '0;
        endcase
    end

    assign ms_final_result = (ms_ld_op != 3'd0) ? ld_data : ms_alu_result;

endmodule
